delay_tap_sched: RTL

Sequencer for the reverb's shared single-port delay-line RAM (2^ADDR_W x DATA_W).
- Clears the RAM after reset.
- Per accepted audio sample: writes the sample at the write pointer, then issues up to NUM_TAPS tap reads spaced TAP_SPACING apart.
- Accumulates a shift-weighted, saturated mix and presents it with a one-cycle valid pulse.
- Sits between the I2S sample-rate domain logic (same clock) and the RAM; replaces the combinational multi-port buffer read.

---
 rtl/delay_tap_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/delay_tap_sched.sv
// Delay-line RAM sequencer: clears the RAM after reset, then per sample writes it
// and reads up to NUM_TAPS spaced taps, producing a shift-weighted saturated mix.
module delay_tap_sched #(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 16,
   parameter int NUM_TAPS    = 4,
   parameter int TAP_SPACING = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   input  logic [2:0]        tap_count,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mix_out,
   output logic              mix_valid,
   output logic              busy,
   output logic              overrun,
   output logic [2:0]        fsm_state
);

   localparam int ACC_W = DATA_W + 2;
   localparam logic [2:0]        MAX_TAPS = 3'(NUM_TAPS);
   localparam logic [ADDR_W-1:0] SPACING  = ADDR_W'(TAP_SPACING);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      CLEAR  = 3'd0,
      IDLE   = 3'd1,
      WRITE  = 3'd2,
      READ   = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t                   state_q;
   logic [ADDR_W-1:0]        clr_addr_q;
   logic [ADDR_W-1:0]        wr_ptr_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [DATA_W-1:0]        x_q;
   logic [2:0]               n_q;
   logic [3:0]               k_q;
   logic [DATA_W-1:0]        mix_out_q;
   logic                     mix_valid_q;
   logic                     overrun_q;

   logic signed [ACC_W-1:0]  rd_ext;
   logic signed [ACC_W-1:0]  x_ext;
   logic signed [ACC_W-1:0]  tap_term;
   logic signed [ACC_W-1:0]  acc_d;
   logic [DATA_W-1:0]        mix_d;
   logic [2:0]               tap_sh;
   logic [2:0]               n_d;
   logic [ADDR_W-1:0]        tap_off;

   // Read data lands one cycle after its READ, so the term added now belongs to tap k-1.
   always_comb begin
      rd_ext   = {{2{mem_rdata[DATA_W-1]}}, mem_rdata};
      x_ext    = {{2{x_q[DATA_W-1]}}, x_q};
      tap_sh   = 3'(k_q - 4'd1);
      tap_term = '0;
      if ((state_q == READ || state_q == FINISH) && k_q > 4'd1) begin
         tap_term = rd_ext >>> tap_sh;
      end
      acc_d = acc_q + tap_term;
      if (acc_d > SAT_MAX) begin
         mix_d = SAT_MAX[DATA_W-1:0];
      end else if (acc_d < SAT_MIN) begin
         mix_d = SAT_MIN[DATA_W-1:0];
      end else begin
         mix_d = acc_d[DATA_W-1:0];
      end
      n_d     = (tap_count > MAX_TAPS) ? MAX_TAPS : tap_count;
      tap_off = SPACING * ADDR_W'(k_q);
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         CLEAR: begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = clr_addr_q;
         end
         WRITE: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_ptr_q;
            mem_wdata = x_q;
         end
         READ: begin
            mem_en   = 1'b1;
            mem_addr = wr_ptr_q - tap_off;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         clr_addr_q  <= '0;
         wr_ptr_q    <= '0;
         acc_q       <= '0;
         x_q         <= '0;
         n_q         <= '0;
         k_q         <= '0;
         mix_out_q   <= '0;
         mix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         mix_valid_q <= 1'b0;
         overrun_q   <= sample_valid && (state_q != IDLE);
         case (state_q)
            CLEAR: begin
               clr_addr_q <= clr_addr_q + 1'b1;
               if (clr_addr_q == '1) state_q <= IDLE;
            end
            IDLE: begin
               if (sample_valid) begin
                  x_q     <= sample_in;
                  n_q     <= n_d;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               acc_q   <= x_ext >>> 1;
               k_q     <= 4'd1;
               state_q <= (n_q != 3'd0) ? READ : FINISH;
            end
            READ: begin
               acc_q <= acc_d;
               k_q   <= k_q + 4'd1;
               if (k_q == {1'b0, n_q}) state_q <= FINISH;
            end
            FINISH: begin
               mix_out_q   <= mix_d;
               mix_valid_q <= 1'b1;
               wr_ptr_q    <= wr_ptr_q + 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

   assign mix_out   = mix_out_q;
   assign mix_valid = mix_valid_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);
   assign fsm_state = state_q;

endmodule
